jtframe_sdram_arb: RTL and testbench
====================================

Name: jtframe_sdram_arb

Overview:
- N-channel round-robin arbiter placed between game-side ROM/RAM clients and the single SDRAM controller request port (sdram_req/ack/data_rdy) in the board layer.
- Replaces ad-hoc per-game muxing of that port.
- Serialises read and write transactions, routes read data back to the owning channel, and holds off new grants while the download/busy condition is asserted.

Parameters:
- CH, 4, number of client channels (2..8).
- AW, 22, SDRAM word address width.
- WW, 16, write data width.
- RW, 32, read data width.

Ports:
- clk_rom  in  1  SDRAM-domain clock.
- rst_n  in  1  synchronous, active-low reset.
- halt  in  1  blocks new grants; in-flight transaction completes.
- ch_req  in  CH  per-channel request; level, held until ch_ack.
- ch_addr  in  CH*AW  per-channel address; channel k occupies bits [k*AW +: AW].
- ch_bank  in  CH*2  per-channel bank.
- ch_rnw  in  CH  1 = read, 0 = write.
- ch_wrmask  in  CH*2  byte mask (active low, written bytes = 0).
- ch_din  in  CH*WW  write data.
- ch_ack  out  CH  one-cycle pulse when the controller accepts that channel's request.
- ch_rdy  out  CH  one-cycle pulse when that channel's transaction completes.
- ch_dout  out  RW  shared read data; valid when any ch_rdy bit is high.
- busy  out  1  high while not in IDLE.
- sdram_req  out  1  controller request.
- sdram_ack  in  1  controller accepted request.
- sdram_addr  out  AW  address to the controller.
- sdram_bank  out  2  bank to the controller.
- sdram_rnw  out  1  read/write select to the controller.
- sdram_wrmask  out  2  byte mask to the controller.
- data_write  out  WW  write data to the controller.
- data_read  in  RW  read data from the controller.
- data_rdy  in  1  transaction done; pulses for writes too.

Behaviour:
- Reset (rst_n = 0 at a clk_rom edge) values:
  - state = IDLE.
  - sdram_req, ch_ack, ch_rdy, busy = 0.
  - ch_dout, sdram_addr, sdram_bank, data_write = 0.
  - sdram_rnw = 1, sdram_wrmask = 2'b11.
  - Round-robin pointer ptr = 0.
- Reset mid-transaction: any pending ack/rdy is dropped. Clients must re-request.
- FSM:
  - IDLE: if halt = 0 and |ch_req, select the first asserted channel g searching ptr, ptr+1, …, mod CH.
    - Register addr, bank, rnw, wrmask and din of g onto the sdram_* outputs.
    - sdram_req = 1, go to REQ.
    - Grant latency is 1 cycle from ch_req visible in IDLE to sdram_req high.
  - REQ: hold sdram_req and all outputs stable. On sdram_ack:
    - sdram_req = 0 on the next edge.
    - ch_ack[g] pulses 1 cycle.
    - Go to WAIT.
  - WAIT: on data_rdy:
    - ch_dout <= data_read.
    - ch_rdy[g] pulses 1 cycle (registered, 1 cycle after data_rdy).
    - ptr <= (g+1) mod CH.
    - Go to IDLE.
- Minimum back-to-back spacing is 1 IDLE cycle between transactions.
- data_rdy arriving in the same cycle as sdram_ack: go straight to IDLE. ch_ack[g] and ch_rdy[g] pulse in the same cycle.
- data_rdy or sdram_ack outside the expected state: ignored.
- ch_req[g] dropping after grant: the transaction still completes and pulses are still issued.
- ch_req changes on non-granted channels during a transaction: no effect.
- halt asserted in REQ or WAIT: no effect until IDLE. IDLE then stays idle while halt = 1.
- Writes return ch_rdy. ch_dout still latches data_read, but the value is meaningless for writes.
- Pointer wraps CH-1 → 0. With all channels requesting continuously, each channel is served once per CH transactions.
- ch_ack and ch_rdy are one-hot or zero in every cycle.

Optional Feature:
- JTFRAME_SDRAM_ARB_PRIO_EN defined: channel 0 has fixed priority. In IDLE, if ch_req[0] = 1 it is granted regardless of ptr. Serving channel 0 leaves ptr unchanged. Other channels rotate as normal.
- Undefined: pure round-robin as above.

Decomposition:
- Package jtframe_sdram_arb_pkg:
  - state enum {IDLE, REQ, WAIT}.
  - Default widths AW = 22, RW = 32, WW = 16.
  - Function for one-hot of an index.
- Sub-module jtframe_arb_rr: combinational rotating-priority encoder.
  - Inputs: req[CH], ptr, prio_en.
  - Outputs: grant index, any.
  - Reusable by other jtframe arbiters.

Test Plan:
- CH = 4, ptr = 0, ch_req = 4'b1010; controller acks after 2 cycles and gives data_rdy 3 cycles later with data_read = 32'hCAFE0001 → channel 1 served first; ch_rdy = 4'b0010, ch_dout = 32'hCAFE0001; then channel 3 is served.
- All four channels requesting continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3.
- halt = 1 while ch_req = 4'b0001 → sdram_req stays 0. Release halt → sdram_req high 1 cycle later.
- Write on channel 2, ch_din = 16'h1234, wrmask = 2'b10 → data_write = 16'h1234, sdram_rnw = 0, sdram_wrmask = 2'b10; ch_rdy[2] pulses after data_rdy.
- Same-cycle sdram_ack and data_rdy → ch_ack[g] and ch_rdy[g] pulse in the same cycle; FSM returns to IDLE.
- rst_n low during WAIT → all outputs at reset values next edge; a later data_rdy is ignored. With JTFRAME_SDRAM_ARB_PRIO_EN and ch_req = 4'b1111, channel 0 wins every grant in which it requests.

Source files
------------

// File: rtl/jtframe_sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM request-port arbiter.
// Default data and address widths match the common jtframe SDRAM controller.
package jtframe_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int DEF_AW = 22;
    localparam int DEF_WW = 16;
    localparam int DEF_RW = 32;
    localparam int MAX_CH = 8;

    function automatic logic [MAX_CH-1:0] onehot(input int idx);
        return MAX_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/jtframe_arb_rr.sv
// Combinational rotating-priority encoder: picks the first request at or after ptr.
// With prio_en set, request 0 overrides the rotation.
module jtframe_arb_rr #(
    parameter int CH = 4,
    parameter int PW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [PW-1:0] ptr,
    input  logic          prio_en,
    output logic [PW-1:0] grant,
    output logic          any
);

    always_comb begin
        grant = '0;
        any   = |req;
        // Walk from the farthest slot back to ptr so the closest match wins.
        for (int i = CH - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % CH]) begin
                grant = PW'((int'(ptr) + i) % CH);
            end
        end
        if (prio_en && req[0]) begin
            grant = '0;
        end
    end

endmodule

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter in front of the single SDRAM controller request port.
// Define JTFRAME_SDRAM_ARB_PRIO_EN to give channel 0 fixed priority over the rotation.
module jtframe_sdram_arb
    import jtframe_sdram_arb_pkg::*;
#(
    parameter int CH = 4,
    parameter int AW = DEF_AW,
    parameter int WW = DEF_WW,
    parameter int RW = DEF_RW
) (
    input  logic              clk_rom,
    input  logic              rst_n,
    input  logic              halt,
    input  logic [CH-1:0]     ch_req,
    input  logic [CH*AW-1:0]  ch_addr,
    input  logic [CH*2-1:0]   ch_bank,
    input  logic [CH-1:0]     ch_rnw,
    input  logic [CH*2-1:0]   ch_wrmask,
    input  logic [CH*WW-1:0]  ch_din,
    output logic [CH-1:0]     ch_ack,
    output logic [CH-1:0]     ch_rdy,
    output logic [RW-1:0]     ch_dout,
    output logic              busy,
    output logic              sdram_req,
    input  logic              sdram_ack,
    output logic [AW-1:0]     sdram_addr,
    output logic [1:0]        sdram_bank,
    output logic              sdram_rnw,
    output logic [1:0]        sdram_wrmask,
    output logic [WW-1:0]     data_write,
    input  logic [RW-1:0]     data_read,
    input  logic              data_rdy
);

    localparam int PW = $clog2(CH);

`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    logic [AW-1:0] addr_a   [CH];
    logic [1:0]    bank_a   [CH];
    logic [1:0]    wrmask_a [CH];
    logic [WW-1:0] din_a    [CH];

    for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
        assign addr_a[gi]   = ch_addr[gi*AW +: AW];
        assign bank_a[gi]   = ch_bank[gi*2 +: 2];
        assign wrmask_a[gi] = ch_wrmask[gi*2 +: 2];
        assign din_a[gi]    = ch_din[gi*WW +: WW];
    end

    logic [PW-1:0] grant;
    logic          any;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] g_q, g_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          req_q, req_d;
    logic [CH-1:0] ack_q, ack_d;
    logic [CH-1:0] rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic [RW-1:0] dout_q, dout_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    bank_q, bank_d;
    logic          rnw_q, rnw_d;
    logic [1:0]    wrmask_q, wrmask_d;
    logic [WW-1:0] wdata_q, wdata_d;
    logic          done;

    jtframe_arb_rr #(
        .CH (CH),
        .PW (PW)
    ) u_rr (
        .req     (ch_req),
        .ptr     (ptr_q),
        .prio_en (PRIO_EN),
        .grant   (grant),
        .any     (any)
    );

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        ptr_d    = ptr_q;
        req_d    = req_q;
        ack_d    = '0;
        rdy_d    = '0;
        dout_d   = dout_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        rnw_d    = rnw_q;
        wrmask_d = wrmask_q;
        wdata_d  = wdata_q;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!halt && any) begin
                    g_d      = grant;
                    addr_d   = addr_a[grant];
                    bank_d   = bank_a[grant];
                    rnw_d    = ch_rnw[grant];
                    wrmask_d = wrmask_a[grant];
                    wdata_d  = din_a[grant];
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    ack_d   = CH'(onehot(int'(g_q)));
                    state_d = WAIT;
                    done    = data_rdy;
                end
            end
            WAIT: begin
                done = data_rdy;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Completion also covers data_rdy landing together with the ack.
        if (done) begin
            dout_d  = data_read;
            rdy_d   = CH'(onehot(int'(g_q)));
            state_d = IDLE;
            if (!(PRIO_EN && g_q == '0)) begin
                ptr_d = PW'((int'(g_q) + 1) % CH);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_rom) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            g_q      <= '0;
            ptr_q    <= '0;
            req_q    <= 1'b0;
            ack_q    <= '0;
            rdy_q    <= '0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
            addr_q   <= '0;
            bank_q   <= '0;
            rnw_q    <= 1'b1;
            wrmask_q <= 2'b11;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            dout_q   <= dout_d;
            addr_q   <= addr_d;
            bank_q   <= bank_d;
            rnw_q    <= rnw_d;
            wrmask_q <= wrmask_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ch_ack       = ack_q;
    assign ch_rdy       = rdy_q;
    assign ch_dout      = dout_q;
    assign busy         = busy_q;
    assign sdram_req    = req_q;
    assign sdram_addr   = addr_q;
    assign sdram_bank   = bank_q;
    assign sdram_rnw    = rnw_q;
    assign sdram_wrmask = wrmask_q;
    assign data_write   = wdata_q;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: table vectors, corner sequences, random traffic.
// Honours JTFRAME_SDRAM_ARB_PRIO_EN in its expectations.
module tb_jtframe_sdram_arb;

    localparam int CH = 4;
    localparam int AW = 22;
    localparam int WW = 16;
    localparam int RW = 32;

`ifdef JTFRAME_SDRAM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic              clk_rom;
    logic              rst_n;
    logic              halt;
    logic [CH-1:0]     ch_req;
    logic [CH*AW-1:0]  ch_addr;
    logic [CH*2-1:0]   ch_bank;
    logic [CH-1:0]     ch_rnw;
    logic [CH*2-1:0]   ch_wrmask;
    logic [CH*WW-1:0]  ch_din;
    logic [CH-1:0]     ch_ack;
    logic [CH-1:0]     ch_rdy;
    logic [RW-1:0]     ch_dout;
    logic              busy;
    logic              sdram_req;
    logic              sdram_ack;
    logic [AW-1:0]     sdram_addr;
    logic [1:0]        sdram_bank;
    logic              sdram_rnw;
    logic [1:0]        sdram_wrmask;
    logic [WW-1:0]     data_write;
    logic [RW-1:0]     data_read;
    logic              data_rdy;

    logic [AW-1:0] addr_v [CH];
    logic [1:0]    bank_v [CH];
    logic [1:0]    wm_v   [CH];
    logic [WW-1:0] din_v  [CH];

    int tests;
    int fails;
    int mptr;

    typedef struct {
        logic [CH-1:0] req;
        logic          rnw;
        int            ack_dly;
        int            rdy_dly;
        bit            same;
        logic [31:0]   rdata;
        int            exp_rr;
        int            exp_prio;
    } vec_t;

    vec_t vecs [8];

    jtframe_sdram_arb #(
        .CH (CH),
        .AW (AW),
        .WW (WW),
        .RW (RW)
    ) dut (
        .clk_rom      (clk_rom),
        .rst_n        (rst_n),
        .halt         (halt),
        .ch_req       (ch_req),
        .ch_addr      (ch_addr),
        .ch_bank      (ch_bank),
        .ch_rnw       (ch_rnw),
        .ch_wrmask    (ch_wrmask),
        .ch_din       (ch_din),
        .ch_ack       (ch_ack),
        .ch_rdy       (ch_rdy),
        .ch_dout      (ch_dout),
        .busy         (busy),
        .sdram_req    (sdram_req),
        .sdram_ack    (sdram_ack),
        .sdram_addr   (sdram_addr),
        .sdram_bank   (sdram_bank),
        .sdram_rnw    (sdram_rnw),
        .sdram_wrmask (sdram_wrmask),
        .data_write   (data_write),
        .data_read    (data_read),
        .data_rdy     (data_rdy)
    );

    initial clk_rom = 1'b0;
    always #5 clk_rom = ~clk_rom;

    always_comb begin
        ch_addr   = '0;
        ch_bank   = '0;
        ch_wrmask = '0;
        ch_din    = '0;
        for (int k = 0; k < CH; k++) begin
            ch_addr[k*AW +: AW]  = addr_v[k];
            ch_bank[k*2 +: 2]    = bank_v[k];
            ch_wrmask[k*2 +: 2]  = wm_v[k];
            ch_din[k*WW +: WW]   = din_v[k];
        end
    end

    function automatic logic [CH-1:0] oh(input int g);
        return CH'(1) << g;
    endfunction

    // Reference: first pending channel scanning ptr, ptr+1, ... (channel 0 first when prioritised).
    function automatic int model_pick(input logic [CH-1:0] r, input int p);
        if (PRIO && r[0]) return 0;
        for (int k = 0; k < CH; k++) begin
            if (r[(p + k) % CH]) return (p + k) % CH;
        end
        return -1;
    endfunction

    function automatic int model_next(input int g, input int p);
        if (PRIO && g == 0) return p;
        return (g + 1) % CH;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},    64'(sdram_req),    64'(0));
        chk({tag, "_busy"},   64'(busy),         64'(0));
        chk({tag, "_ack"},    64'(ch_ack),       64'(0));
        chk({tag, "_rdy"},    64'(ch_rdy),       64'(0));
        chk({tag, "_dout"},   64'(ch_dout),      64'(0));
        chk({tag, "_addr"},   64'(sdram_addr),   64'(0));
        chk({tag, "_bank"},   64'(sdram_bank),   64'(0));
        chk({tag, "_wdata"},  64'(data_write),   64'(0));
        chk({tag, "_rnw"},    64'(sdram_rnw),    64'(1));
        chk({tag, "_wrmask"}, 64'(sdram_wrmask), 64'(2'b11));
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        halt      = 1'b0;
        ch_req    = '0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        repeat (2) @(negedge clk_rom);
        chk_reset_vals("rst");
        rst_n = 1'b1;
    endtask

    // One full transaction as seen by the controller; returns at the negedge where ch_rdy is visible.
    task automatic do_txn(input int g, input int lat, input int ack_dly, input int rdy_dly,
                          input bit same, input bit keep, input logic [CH-1:0] extra,
                          input logic [31:0] rdata);
        int n;
        n = 0;
        while (!sdram_req && n < 30) begin
            @(negedge clk_rom);
            n++;
        end
        chk("req_seen", 64'(sdram_req), 64'(1));
        if (lat >= 0) chk("grant_lat", 64'(n), 64'(lat));
        chk("busy", 64'(busy), 64'(1));
        chk("addr", 64'(sdram_addr), 64'(addr_v[g]));
        chk("bank", 64'(sdram_bank), 64'(bank_v[g]));
        chk("rnw", 64'(sdram_rnw), 64'(ch_rnw[g]));
        chk("wrmask", 64'(sdram_wrmask), 64'(wm_v[g]));
        chk("wdata", 64'(data_write), 64'(din_v[g]));
        repeat (ack_dly) begin
            @(negedge clk_rom);
            chk("req_hold", 64'(sdram_req), 64'(1));
        end
        sdram_ack = 1'b1;
        data_rdy  = same;
        data_read = rdata;
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        chk("ch_ack", 64'(ch_ack), 64'(oh(g)));
        chk("req_drop", 64'(sdram_req), 64'(0));
        ch_req = (ch_req | extra) & ~(keep ? CH'(0) : oh(g));
        if (!same) begin
            chk("early_rdy", 64'(ch_rdy), 64'(0));
            repeat (rdy_dly) @(negedge clk_rom);
            data_rdy  = 1'b1;
            data_read = rdata;
            @(negedge clk_rom);
            data_rdy = 1'b0;
            chk("ack_once", 64'(ch_ack), 64'(0));
        end
        chk("ch_rdy", 64'(ch_rdy), 64'(oh(g)));
        chk("ch_dout", 64'(ch_dout), 64'(rdata));
        chk("busy_end", 64'(busy), 64'(0));
        $display("[TB] txn ch=%0d rnw=%0b ack_dly=%0d same=%0b data=%08h", g, ch_rnw[g], ack_dly, same, rdata);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int k = 0; k < CH; k++) begin
            addr_v[k] = AW'(22'h100000 + k * 22'h01111);
            bank_v[k] = 2'(k);
        end
        wm_v[0] = 2'b01; wm_v[1] = 2'b11; wm_v[2] = 2'b10; wm_v[3] = 2'b00;
        din_v[0] = 16'hA000; din_v[1] = 16'hB001; din_v[2] = 16'h1234; din_v[3] = 16'hD003;
        ch_rnw = '1;

        vecs[0] = '{4'b1010, 1'b1, 2, 2, 1'b0, 32'hCAFE0001, 1, 1};
        vecs[1] = '{4'b1000, 1'b1, 0, 1, 1'b0, 32'hCAFE0002, 3, 3};
        vecs[2] = '{4'b0110, 1'b1, 1, 0, 1'b1, 32'h5A5A0003, 1, 1};
        vecs[3] = '{4'b0111, 1'b1, 0, 0, 1'b0, 32'h0BAD0004, 2, 0};
        vecs[4] = '{4'b0011, 1'b1, 3, 2, 1'b0, 32'h12340005, 0, 0};
        vecs[5] = '{4'b1001, 1'b1, 1, 1, 1'b1, 32'h87650006, 3, 0};
        vecs[6] = '{4'b1111, 1'b1, 0, 3, 1'b0, 32'hFFFF0007, 0, 0};
        vecs[7] = '{4'b0100, 1'b0, 2, 1, 1'b0, 32'h00000008, 2, 2};

        // Table-driven sequence from reset.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            ch_req = vecs[i].req;
            ch_rnw = vecs[i].rnw ? 4'b1111 : 4'b0000;
            do_txn(PRIO ? vecs[i].exp_prio : vecs[i].exp_rr, 1, vecs[i].ack_dly, vecs[i].rdy_dly,
                   vecs[i].same, 1'b0, 4'b0000, vecs[i].rdata);
        end
        ch_req = '0;
        ch_rnw = '1;

        // All channels requesting continuously.
        reset_dut();
        ch_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            do_txn(PRIO ? 0 : (i % CH), 1, 1, 1, 1'b0, 1'b1, 4'b0000, 32'h3000_0000 + 32'(i));
        end
        ch_req = '0;

        // Halt blocks grants but never a transaction already granted.
        reset_dut();
        halt   = 1'b1;
        ch_req = 4'b0001;
        repeat (4) begin
            @(negedge clk_rom);
            chk("halt_block", 64'(sdram_req), 64'(0));
        end
        halt = 1'b0;
        @(negedge clk_rom);
        chk("halt_release", 64'(sdram_req), 64'(1));
        halt = 1'b1;
        do_txn(0, 0, 2, 1, 1'b0, 1'b1, 4'b0000, 32'h4A17_0001);
        repeat (3) begin
            @(negedge clk_rom);
            chk("halt_after", 64'(sdram_req), 64'(0));
        end
        halt = 1'b0;
        do_txn(0, 1, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h4A17_0002);

        // Stray ack/rdy while idle are ignored.
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        @(negedge clk_rom);
        chk("stray_ack", 64'(ch_ack), 64'(0));
        chk("stray_rdy", 64'(ch_rdy), 64'(0));
        chk("stray_busy", 64'(busy), 64'(0));

        // Reset while waiting for data drops the transaction.
        reset_dut();
        ch_req = 4'b0100;
        @(negedge clk_rom);
        chk("mid_req", 64'(sdram_req), 64'(1));
        sdram_ack = 1'b1;
        @(negedge clk_rom);
        sdram_ack = 1'b0;
        ch_req    = '0;
        rst_n     = 1'b0;
        @(negedge clk_rom);
        chk_reset_vals("midrst");
        rst_n     = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'hDEAD_BEEF;
        @(negedge clk_rom);
        data_rdy = 1'b0;
        @(negedge clk_rom);
        chk("late_rdy", 64'(ch_rdy), 64'(0));
        chk("late_dout", 64'(ch_dout), 64'(0));

        // Random traffic against the reference model.
        reset_dut();
        mptr = 0;
        for (int t = 0; t < 40; t++) begin
            int g;
            for (int k = 0; k < CH; k++) begin
                addr_v[k] = AW'($urandom);
                bank_v[k] = 2'($urandom);
                wm_v[k]   = 2'($urandom);
                din_v[k]  = WW'($urandom);
            end
            ch_rnw = CH'($urandom);
            ch_req = ch_req | CH'($urandom);
            if (ch_req == '0) ch_req = oh(int'($urandom_range(0, CH - 1)));
            if ($urandom_range(0, 3) == 0) begin
                halt = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk_rom);
                    chk("rand_halt", 64'(sdram_req), 64'(0));
                end
                halt = 1'b0;
            end
            g = model_pick(ch_req, mptr);
            do_txn(g, -1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 1'b0, CH'($urandom), $urandom);
            mptr = model_next(g, mptr);
        end
        ch_req = '0;
        @(negedge clk_rom);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
